// File: rtl/nsa_pkg.sv
// ============================================================================
// Module      : nsa_pkg
// Description : Shared types and helpers for the nibble serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    // Counter width for a digit index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serial_adder_rca4.sv
// ============================================================================
// Module      : nibble_serial_adder_rca4
// Description : 4-bit ripple-carry adder, the single-nibble datapath stage.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nibble_serial_adder_rca4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign cout = w_c[4];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module      : nibble_serial_adder
// Description : Wide adder that reuses one 4-bit adder, one nibble per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                    cout,
    output logic                    busy
);

    localparam int            c_W    = NIBBLE_W * NIBBLES;
    localparam int            c_CW   = cnt_width(NIBBLES);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NIBBLES - 1);

    nsa_state_t       r_state;
    logic [c_W-1:0]   r_a;
    logic [c_W-1:0]   r_b;
    logic             r_carry;
    logic [c_CW-1:0]  r_cnt;

    logic [NIBBLE_W-1:0] w_sum_nib;
    logic                w_cout;
    logic [c_W-1:0]      w_res_next;
    logic                w_accept;

    assign in_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state == ADD);

    nibble_serial_adder_rca4 u_rca4 (
        .A    (r_a[NIBBLE_W-1:0]),
        .B    (r_b[NIBBLE_W-1:0]),
        .cin  (r_carry),
        .sum  (w_sum_nib),
        .cout (w_cout)
    );

    // Partial result: each new nibble enters at the top, so after NIBBLES
    // steps the least-significant digit has reached bit 0.
    if (NIBBLES > 1) begin : g_multi
        logic [c_W-NIBBLE_W-1:0] r_res;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_res <= '0;
            end else if (r_state == ADD) begin
                r_res <= w_res_next[c_W-1:NIBBLE_W];
            end
        end

        assign w_res_next = {w_sum_nib, r_res};
    end else begin : g_single
        assign w_res_next = w_sum_nib;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (w_accept) begin
            r_a       <= a;
            r_b       <= b;
            r_carry   <= cin;
            r_cnt     <= '0;
            r_state   <= ADD;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                ADD: begin
                    r_a     <= r_a >> NIBBLE_W;
                    r_b     <= r_b >> NIBBLE_W;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                        sum       <= w_res_next;
                        cout      <= w_cout;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module      : tb_nibble_serial_adder
// Description : Scoreboard bench for the 4-nibble and 1-nibble adder builds.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, out_ready, cin;
    logic [15:0] a, b;
    logic        in_ready, out_valid, cout, busy;
    logic [15:0] sum;

    logic        in_valid1, out_ready1, cin1;
    logic [3:0]  a1, b1;
    logic        in_ready1, out_valid1, cout1, busy1;
    logic [3:0]  sum1;

    int          errors = 0;
    int          checks = 0;
    logic [16:0] exp_q[$];
    logic [16:0] e;
    int          n, bc;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic send(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        exp_q.push_back({1'b0, ta} + {1'b0, tb_} + 17'(tc));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // n = edges from acceptance to out_valid (-1 on timeout), bc = busy cycles.
    task automatic wait_valid(output int nn, output int bcc);
        nn  = -1;
        bcc = busy ? 1 : 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                nn = i;
                break;
            end
            if (busy) bcc++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== 16'h0) begin errors++; $display("FAIL reset_sum: got %h want 0000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({in_ready1, out_valid1, busy1} !== 3'b100) begin errors++; $display("FAIL reset_n1: got %b want 100", {in_ready1, out_valid1, busy1}); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        send(16'h1234, 16'h4321, 1'b0);
        wait_valid(n, bc);
        e = exp_q.pop_front();
        checks++; if (n !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", n); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
        checks++; if (sum !== e[15:0]) begin errors++; $display("FAIL basic_sum: got %h want %h", sum, e[15:0]); end
        checks++; if (cout !== e[16]) begin errors++; $display("FAIL basic_cout: got %b want %b", cout, e[16]); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_hs_valid: got %b want 0", out_valid); end
        checks++; if (sum !== 16'h5555) begin errors++; $display("FAIL basic_sum_held: got %h want 5555", sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_carry();
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_valid(n, bc);
        e = exp_q.pop_front();
        checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL carry_ripple: got %b_%h want %b_%h", cout, sum, e[16], e[15:0]); end
        @(posedge clk);
        #1;
        send(16'h0000, 16'h0000, 1'b1);
        wait_valid(n, bc);
        e = exp_q.pop_front();
        checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL carry_cin: got %b_%h want %b_%h", cout, sum, e[16], e[15:0]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0);
        wait_valid(n, bc);
        e = exp_q.pop_front();
        checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL bp_result: got %b_%h want %b_%h", cout, sum, e[16], e[15:0]); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin a = 16'hAAAA; b = 16'h0000; in_valid = 1'b1; end
            if (i == 2) in_valid = 1'b0;
            @(posedge clk);
            #1;
            checks++; if ({out_valid, cout, sum} !== {1'b1, e}) begin errors++; $display("FAIL bp_hold: got %b_%b_%h want 1_%b_%h", out_valid, cout, sum, e[16], e[15:0]); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_to_idle: got valid/busy %b want 00", {out_valid, busy}); end
    endtask

    task automatic test_back_to_back();
        send(16'h0123, 16'h0456, 1'b0);
        wait_valid(n, bc);
        e = exp_q.pop_front();
        checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL b2b_first: got %b_%h want %b_%h", cout, sum, e[16], e[15:0]); end
        a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1;
        exp_q.push_back({1'b0, a} + {1'b0, b});
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if ({busy, out_valid} !== 2'b10) begin errors++; $display("FAIL b2b_reaccept: got busy/valid %b want 10", {busy, out_valid}); end
        wait_valid(n, bc);
        checks++; if (n + 1 !== 5) begin errors++; $display("FAIL b2b_spacing: got %0d want 5", n + 1); end
        e = exp_q.pop_front();
        checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL b2b_second: got %b_%h want %b_%h", cout, sum, e[16], e[15:0]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        send(16'h7000, 16'h9001, 1'b0);
        wait_valid(n, bc);
        e = exp_q.pop_front();
        checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL rst_pre: got %b_%h want %b_%h", cout, sum, e[16], e[15:0]); end
        @(posedge clk);
        #1;
        send(16'h1111, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        checks++; if ({out_valid, cout, busy} !== 3'b000) begin errors++; $display("FAIL rst_async_flags: got %b want 000", {out_valid, cout, busy}); end
        checks++; if (sum !== 16'h0) begin errors++; $display("FAIL rst_async_sum: got %h want 0000", sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b want 1", in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL rst_no_partial: got %b want 00", {out_valid, busy}); end
        send(16'h0F0F, 16'h00F1, 1'b0);
        wait_valid(n, bc);
        e = exp_q.pop_front();
        checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL rst_after: got %b_%h want %b_%h", cout, sum, e[16], e[15:0]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom));
            wait_valid(n, bc);
            e = exp_q.pop_front();
            checks++; if ({cout, sum} !== e || n !== 4) begin errors++; $display("FAIL rand_%0d: got %b_%h lat %0d want %b_%h lat 4", k, cout, sum, n, e[16], e[15:0]); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_nibbles1();
        logic [3:0] va [2];
        logic [3:0] vb [2];
        logic       vc [2];
        int         m;
        va[0] = 4'h9; vb[0] = 4'h8; vc[0] = 1'b1;
        va[1] = 4'h3; vb[1] = 4'h4; vc[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            a1 = va[k]; b1 = vb[k]; cin1 = vc[k]; in_valid1 = 1'b1;
            exp_q.push_back(17'(a1) + 17'(b1) + 17'(cin1));
            @(posedge clk);
            #1;
            in_valid1 = 1'b0;
            checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL n1_busy_%0d: got %b want 1", k, busy1); end
            m = -1;
            for (int i = 1; i <= 16; i++) begin
                @(posedge clk);
                #1;
                if (out_valid1) begin m = i; break; end
            end
            e = exp_q.pop_front();
            checks++; if (m !== 1) begin errors++; $display("FAIL n1_latency_%0d: got %0d want 1", k, m); end
            checks++; if ({cout1, sum1} !== {e[4], e[3:0]}) begin errors++; $display("FAIL n1_result_%0d: got %b_%h want %b_%h", k, cout1, sum1, e[4], e[3:0]); end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_nibbles1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-nibble serial adder front end. Accepts two NIBBLES×4-bit operands plus a carry-in over a valid/ready handshake.
- Adds the operands one nibble per clock by driving the team's existing 4-bit ripple-carry adder (ports A, B, cin, sum, cout). Each nibble's carry-out is registered and fed back as the next nibble's carry-in.
- Presents the full-width sum and final carry-out on a valid/ready output port.
- Sits directly upstream of, and consumes, the 4-bit adder stage. It lets wide additions reuse the single nibble adder.

Parameters:
- NIBBLES, 4, number of 4-bit digits per operand (operand width W = 4*NIBBLES); legal range 1..16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept an operand bundle.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in to the least-significant nibble.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  W  A + B + cin, modulo 2^W.
- cout  out  1  carry-out of the most-significant nibble.
- busy  out  1  high while in state ADD.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, out_valid=0, sum=0, cout=0, busy=0, nibble counter=0, carry register=0, operand shift registers=0. in_ready=1 while reset is held.
- Reset mid-operation aborts the add. No partial result is ever presented.
- State machine has three states: IDLE, ADD, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from the state and out_ready only, with no dependence on in_valid.
- Accept: on an edge where in_valid && in_ready:
  - latch a and b into shift registers;
  - carry register <= cin;
  - counter <= 0;
  - state <= ADD.
- ADD, each edge:
  - adder inputs are the low nibble of each shift register and the carry register;
  - the adder's sum nibble is shifted into the result register from the MSB end;
  - both operand shift registers shift right by 4;
  - carry register <= adder cout;
  - counter++.
- ADD exit: on the edge where counter==NIBBLES-1, state <= DONE and out_valid <= 1. sum takes the fully assembled result and cout takes the final carry.
- Latency: with acceptance on edge k, out_valid is first high after edge k+NIBBLES.
- While ADD: in_ready=0. in_valid is ignored and a/b/cin are not sampled.
- DONE: out_valid=1. sum and cout are held stable until the handshake completes.
  - out_ready && !in_valid -> IDLE, out_valid <= 0.
  - out_ready && in_valid -> accept the new bundle on the same edge, go directly to ADD, out_valid <= 0.
  - The back-to-back throughput is one result per NIBBLES+1 cycles.
- sum/cout keep their last values after the handshake (out_valid=0). They are cleared only by reset.
- NIBBLES=1: ADD lasts exactly one cycle.
- Overflow wraps modulo 2^W. The overflow is reported only via cout. No signed interpretation.

Decomposition:
- Package nsa_pkg holds:
  - NIBBLE_W = 4;
  - state enum typedef {IDLE, ADD, DONE} (2-bit encoding);
  - counter width function clog2(NIBBLES), with a minimum of 1.
- The one sub-module is the team's existing 4-bit ripple-carry adder, instantiated once as the datapath.
- FSM, counter, carry register and shift registers stay inline in nibble_serial_adder.

Test Plan:
- NIBBLES=4: a=0x1234, b=0x4321, cin=0, handshake on edge k -> out_valid rises after edge k+4, sum=0x5555, cout=0; busy high for exactly 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through every nibble: sum=0x0000, cout=1. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout unchanged and in_ready=0. in_valid pulsed with a=0xAAAA in that window is ignored. Then out_ready=1 -> IDLE.
- Back-to-back: in DONE assert out_ready=1 and in_valid=1 with a=0x8000, b=0x8000, cin=0 -> new bundle accepted on the same edge, next result sum=0x0000, cout=1, 5-cycle spacing between out_valid rises.
- Reset mid-ADD: pull reset_n low after 2 ADD cycles -> out_valid, sum, cout and busy go to 0 immediately (asynchronous); in_ready=1. After release, a=0x0F0F, b=0x00F1, cin=0 -> sum=0x1000, cout=0.
- NIBBLES=1 build: a=0x9, b=0x8, cin=1 -> out_valid after 1 cycle, sum=0x2, cout=1.
